uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters, using round-robin arbitration with message-level grants.
- A grant is held across a multi-byte message until req_last is sent, the burst limit is reached, or the hold timeout expires.
- Sequences the transmitter's tx_start/tx_busy handshake and holds tx_data stable for the whole frame, because the transmitter samples data bits combinationally on baud ticks.
- Sits between system message sources (debug console, status reporter, etc.) and the UART TX.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced rotation.
- HOLD_TIMEOUT, 1024, clk cycles to wait in HOLD for the next byte before releasing the grant.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  one-hot, one-cycle byte-accept pulse.
- tx_start  out  1  start request to the transmitter.
- tx_data  out  8  byte to the transmitter; registered, stable while a frame is in flight.
- tx_busy  in  1  transmitter busy (non-idle).
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester.
- active  out  1  a grant is held (any state other than IDLE).
- byte_sent  out  1  one-cycle pulse when a frame completes (tx_busy falls).

Behaviour:
- Reset: rst has priority over all other events and may assert at any time, including mid-frame.
  - Outputs: tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, byte_sent=0.
  - Internal: rr pointer last=NUM_REQ-1 (requester 0 wins first), burst_cnt=0, hold_cnt=0, state=IDLE.
  - The transmitter is reset by the same rst.
- A transfer occurs when req_valid[i] & req_ready[i]. Data and last are latched into tx_data/last_q on that cycle.
- req_ready is asserted only in IDLE (for the winner) or in HOLD (for the granted requester). It is never asserted to two requesters at once.
- IDLE:
  - If any req_valid: pick the first valid requester searching from last+1 with wrap-around.
  - Same cycle: req_ready[g]=1, latch byte, grant_id<=g, burst_cnt<=1, go START.
- START:
  - tx_start=1, held until tx_busy==1 is observed; this tolerates a baud tick arriving many clk cycles later.
  - Then drop tx_start and go SEND.
- SEND:
  - Wait for tx_busy==0. On that cycle: byte_sent=1.
  - If last_q, or burst_cnt==MAX_BURST: last<=grant_id, go IDLE.
  - Otherwise: hold_cnt<=0, go HOLD.
- HOLD:
  - If req_valid[grant_id]: req_ready pulse, latch byte, burst_cnt+1, go START.
  - Else hold_cnt+1. If hold_cnt==HOLD_TIMEOUT-1: release the grant (last<=grant_id, go IDLE).
  - Other requesters' valids are ignored while in HOLD.
- Latency: an IDLE request is accepted the same cycle it is seen, and tx_start rises the following cycle.
- Boundary conditions:
  - req_valid deasserting after acceptance has no effect; the byte is already latched.
  - A MAX_BURST rotation does not mark the message complete. The requester re-arbitrates, and its remaining bytes continue after other requesters are served.
  - With a single active requester, it is re-granted immediately from IDLE.
  - tx_busy already high on entry to START holds tx_start until busy is seen. This cannot happen in normal operation; the bench flags it as an assertion.
- Counters: burst_cnt width $clog2(MAX_BURST+1); hold_cnt width $clog2(HOLD_TIMEOUT). No wrap; both are cleared on every new grant.

Optional Feature:
- Macro: UART_ARB_PRIO_EN.
- Defined: requester 0 is strict-priority. In IDLE it wins whenever valid, regardless of the rr pointer, and is never forced to rotate by MAX_BURST (the burst limit is ignored for grant 0). Requesters 1..NUM_REQ-1 round-robin among themselves.
- Undefined: all requesters are equal round-robin, as described above.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, START, SEND, HOLD);
  - default constants NUM_REQ_DEF=4, MAX_BURST_DEF=16, HOLD_TIMEOUT_DEF=1024;
  - byte width constant 8.
- Sub-module rr_pick (combinational): inputs valid vector and last pointer; outputs a found flag and the winner index. It is reused by other arbiters in the codebase.

Test Plan:
- Single message: req 1 sends 0x41,0x42,0x43 (last on 0x43) -> three frames in order on the line, byte_sent x3, req_ready[1] x3, then IDLE, active=0.
- Contention: reqs 0 and 2 both valid with one-byte messages (0x10 and 0x20) in the same cycle -> 0x10 sent first, then 0x20. The next simultaneous pair starts with req 2's successor in rr order.
- Burst limit: MAX_BURST=4, req 0 streams 6 bytes 0x00..0x05 while req 1 holds 0xAA -> line order 00,01,02,03,AA,04,05.
- Hold timeout: req 3 sends 0x55 without last, then idles -> grant released exactly HOLD_TIMEOUT cycles after entering HOLD; req 1's pending 0x77 is then accepted.
- Reset mid-frame: assert rst during bit 4 of 0x5A -> next cycle tx_start=0, tx_data=0, active=0, req_ready=0. After release, requester 0 is granted first.
- UART_ARB_PRIO_EN: req 1 mid-message (HOLD) while req 0 becomes valid -> req 1 keeps the grant until its last byte; req 0 then wins over a waiting req 2.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter.
// Build option: UART_ARB_PRIO_EN makes requester 0 strict-priority.
package uart_arb_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int MAX_BURST_DEF    = 16;
  localparam int HOLD_TIMEOUT_DEF = 1024;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid
// searching upward from last+1 with wrap-around.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (valid[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-level arbiter sharing one UART TX.
// Build option: UART_ARB_PRIO_EN makes requester 0 strict-priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic                        byte_sent
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int HW = $clog2(HOLD_TIMEOUT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

  state_t            state;
  logic [GW-1:0]     last;
  logic [BW-1:0]     burst_cnt;
  logic [HW-1:0]     hold_cnt;
  logic              last_q;

  logic [NUM_REQ-1:0] pick_vec;
  logic               rr_found;
  logic [GW-1:0]      rr_idx;
  logic               win_found;
  logic [GW-1:0]      win_idx;
  logic               burst_hit;
  logic               idle_take;
  logic               hold_take;
  logic [GW-1:0]      take_idx;
  logic [BYTE_W-1:0]  take_byte;
  logic               take_last;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (pick_vec),
    .last  (last),
    .found (rr_found),
    .idx   (rr_idx)
  );

`ifdef UART_ARB_PRIO_EN
  // Requester 0 bypasses the ring; the rest rotate among themselves.
  assign pick_vec  = {req_valid[NUM_REQ-1:1], 1'b0};
  assign win_found = req_valid[0] | rr_found;
  assign win_idx   = req_valid[0] ? '0 : rr_idx;
  assign burst_hit = (burst_cnt == BURST_MAX) && (grant_id != '0);
`else
  assign pick_vec  = req_valid;
  assign win_found = rr_found;
  assign win_idx   = rr_idx;
  assign burst_hit = (burst_cnt == BURST_MAX);
`endif

  assign idle_take = (state == IDLE) && win_found;
  assign hold_take = (state == HOLD) && req_valid[grant_id];
  assign take_idx  = idle_take ? win_idx : grant_id;
  assign take_byte = req_data[take_idx*BYTE_W +: BYTE_W];
  assign take_last = req_last[take_idx];

  always_comb begin
    req_ready = '0;
    if (!rst) begin
      unique case (1'b1)
        idle_take: req_ready[win_idx]  = 1'b1;
        hold_take: req_ready[grant_id] = 1'b1;
        default:   req_ready = '0;
      endcase
    end
  end

  assign tx_start  = (state == START);
  assign active    = (state != IDLE);
  assign byte_sent = (state == SEND) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= GW'(NUM_REQ - 1);
      grant_id  <= '0;
      burst_cnt <= '0;
      hold_cnt  <= '0;
      last_q    <= 1'b0;
      tx_data   <= '0;
    end else begin
      if (idle_take || hold_take) begin
        tx_data <= take_byte;
        last_q  <= take_last;
      end
      unique case (state)
        IDLE: if (win_found) begin
          grant_id  <= win_idx;
          burst_cnt <= BW'(1);
          hold_cnt  <= '0;
          state     <= START;
        end
        START: if (tx_busy) state <= SEND;
        SEND: if (!tx_busy) begin
          if (last_q || burst_hit) begin
            last  <= grant_id;
            state <= IDLE;
          end else begin
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (req_valid[grant_id]) begin
            // Saturates: an unlimited priority grant must not wrap.
            if (burst_cnt != BURST_MAX)
              burst_cnt <= burst_cnt + 1'b1;
            state <= START;
          end else if (hold_cnt == HOLD_LAST) begin
            last  <= grant_id;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a message-level
// reference model and a behavioural UART transmitter.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int HT  = 40;
  localparam int BIT = 4;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;
  logic          byte_sent;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .MAX_BURST    (MB),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .byte_sent (byte_sent)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [8:0] src_q[NR][$];
  logic [8:0] bq[NR][$];
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt[NR];
  int bs_cnt = 0;
  int m_last;
  int ph, bits, cnt, wait_n;
  logic [7:0] cap;
  exp_t e;

  function automatic void chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endfunction

  assert property (@(posedge clk) disable iff (rst)
    $rose(tx_start) |-> !tx_busy)
  else begin
    n_bad++;
    $display("FAIL start_busy: tx_busy high on START entry");
  end

  // Requester sources: present queue fronts, pop on handshake.
  initial begin : drv
    logic [NR-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          void'(src_q[i].pop_front());
          acc_cnt[i]++;
        end
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // UART transmitter model; frame start feeds the scoreboard.
  initial begin : uart
    tx_busy = 1'b0;
    ph = 0; bits = 0; cnt = 0; wait_n = 0; cap = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        tx_busy = 1'b0;
        ph = 0;
      end else if (ph == 0) begin
        if (tx_start) begin
          wait_n = $urandom_range(0, 4);
          ph = 1;
        end
      end else if (ph == 1) begin
        if (wait_n == 0) begin
          tx_busy = 1'b1;
          cap = tx_data;
          bits = 0;
          cnt = 0;
          ph = 2;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame: unexpected byte %h", cap);
          end else begin
            e = exp_q.pop_front();
            chk("frame data", int'(cap), int'(e.d));
            chk("frame grant", int'(grant_id), int'(e.g));
          end
        end else begin
          wait_n--;
        end
      end else begin
        if (cnt == BIT - 1) begin
          cnt = 0;
          chk("tx_data stable", int'(tx_data), int'(cap));
          bits++;
          if (bits == 10) begin
            tx_busy = 1'b0;
            ph = 0;
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (byte_sent) bs_cnt++;
      if (req_ready != '0)
        chk("req_ready onehot", int'($onehot(req_ready)), 1);
    end
  end

  // Message-level model: whole messages, burst-capped, in ring order.
  function automatic void predict();
    logic [8:0] mq[NR][$];
    logic [8:0] x;
    int g, n, j;
    bit p0, done;
    p0 = 1'b0;
`ifdef UART_ARB_PRIO_EN
    p0 = 1'b1;
`endif
    for (int i = 0; i < NR; i++) mq[i] = bq[i];
    forever begin
      g = -1;
      if (p0 && mq[0].size() > 0) g = 0;
      for (int k = 1; k <= NR; k++) begin
        j = (m_last + k) % NR;
        if (g < 0 && !(p0 && j == 0) && mq[j].size() > 0) g = j;
      end
      if (g < 0) break;
      n = 0;
      done = 1'b0;
      while (!done) begin
        x = mq[g].pop_front();
        exp_q.push_back({2'(g), x[7:0]});
        n++;
        done = x[8] || mq[g].size() == 0 || (n == MB && !(p0 && g == 0));
      end
      m_last = g;
    end
  endfunction

  task automatic drain(input string nm);
    int n;
    bit srcs;
    n = 0;
    forever begin
      srcs = 1'b0;
      for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) srcs = 1'b1;
      if (!(srcs || exp_q.size() > 0 || active || ph != 0) || n >= 20000)
        break;
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s drain: timeout, %0d bytes outstanding", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk({nm, " active"}, int'(active), 0);
  endtask

  task automatic run_batch(input string nm);
    int tot;
    tot = 0;
    predict();
    bs_cnt = 0;
    for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
    for (int i = 0; i < NR; i++) begin
      tot += bq[i].size();
      foreach (bq[i][k]) src_q[i].push_back(bq[i][k]);
    end
    drain(nm);
    for (int i = 0; i < NR; i++)
      chk({nm, " accepts"}, acc_cnt[i], bq[i].size());
    chk({nm, " byte_sent"}, bs_cnt, tot);
    for (int i = 0; i < NR; i++) bq[i].delete();
  endtask

  task automatic wait_sent(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!byte_sent && n < 2000);
    if (!byte_sent) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no byte_sent within %0d cycles", nm, n);
    end
  endtask

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d bad", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, len, nm;
    rst = 1'b1;
    m_last = NR - 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tx_start", int'(tx_start), 0);
    chk("rst tx_data", int'(tx_data), 0);
    chk("rst active", int'(active), 0);
    chk("rst grant_id", int'(grant_id), 0);
    chk("rst byte_sent", int'(byte_sent), 0);
    chk("rst req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    bq[0].push_back(9'h110);
    bq[2].push_back(9'h120);
    run_batch("contention");

    bq[0].push_back(9'h111);
    bq[3].push_back(9'h113);
    run_batch("contention2");

    bq[1].push_back(9'h041);
    bq[1].push_back(9'h042);
    bq[1].push_back(9'h143);
    run_batch("single");

    for (int k = 0; k < 6; k++) bq[0].push_back({k == 5, 8'(k)});
    bq[1].push_back(9'h1AA);
    run_batch("burst");

    // Hold timeout: released HT cycles into HOLD, then req 1 wins.
    exp_q.push_back({2'd3, 8'h55});
    src_q[3].push_back(9'h055);
    wait_sent("timeout first");
    exp_q.push_back({2'd1, 8'h77});
    src_q[1].push_back(9'h177);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[1] && n < HT + 20);
    chk("hold timeout cycles", n, HT + 1);
    m_last = 1;
    drain("timeout");

    // Reset in the middle of a frame.
    exp_q.push_back({2'd2, 8'h5A});
    src_q[2].push_back(9'h15A);
    n = 0;
    while (!(ph == 2 && bits == 4) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reset reached bit 4", int'(ph == 2 && bits == 4), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    src_q[0].push_back(9'h13C);
    src_q[3].push_back(9'h1C3);
    exp_q.push_back({2'd0, 8'h3C});
    exp_q.push_back({2'd3, 8'hC3});
    @(posedge clk);
    @(negedge clk);
    chk("midrst tx_start", int'(tx_start), 0);
    chk("midrst tx_data", int'(tx_data), 0);
    chk("midrst active", int'(active), 0);
    chk("midrst req_ready", int'(req_ready), 0);
    chk("midrst grant_id", int'(grant_id), 0);
    chk("midrst byte_sent", int'(byte_sent), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_last = 3;
    drain("midrst");

`ifdef UART_ARB_PRIO_EN
    exp_q.push_back({2'd1, 8'hB1});
    exp_q.push_back({2'd1, 8'hB2});
    exp_q.push_back({2'd1, 8'hB3});
    src_q[1].push_back(9'h0B1);
    src_q[1].push_back(9'h0B2);
    src_q[1].push_back(9'h1B3);
    wait_sent("prio first");
    exp_q.push_back({2'd0, 8'hC0});
    exp_q.push_back({2'd2, 8'hC2});
    src_q[0].push_back(9'h1C0);
    src_q[2].push_back(9'h1C2);
    m_last = 2;
    drain("prio");
`endif

    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          nm = $urandom_range(1, 2);
          for (int m = 0; m < nm; m++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
              bq[i].push_back({k == len - 1, 8'($urandom)});
          end
        end
      end
      run_batch("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
